// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the four-phase req/ack source controller:
// state encoding and timeout timer sizing.
package cdc_handshake_tx_pkg;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StRel  = 2'd2;

   // Bits needed to hold timeout-1; never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cdc_simple.sv
// Single-bit level synchronizer: one capture flop followed by pPIPE_DEPTH
// resolution stages, cleared by the source-domain reset.
module cdc_simple #(
   parameter int unsigned pPIPE_DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic data_in,
   output logic data_out
);

   logic [pPIPE_DEPTH:0] pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe <= '0;
      end else begin
         pipe <= {pipe[pPIPE_DEPTH-1:0], data_in};
      end
   end

   assign data_out = pipe[pPIPE_DEPTH];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack crossing: holds one word on xfer_data
// and sequences xfer_req against the synchronized destination acknowledge.
module cdc_handshake_tx
   import cdc_handshake_tx_pkg::*;
#(
   parameter int unsigned pWIDTH      = 32,
   parameter int unsigned pSYNC_DEPTH = 2,
   parameter int unsigned pTIMEOUT    = 1024,
   parameter int unsigned pCNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [pWIDTH-1:0]     s_data,
   output logic [pWIDTH-1:0]     xfer_data,
   output logic                  xfer_req,
   input  logic                  xfer_ack,
   output logic                  busy,
   output logic                  timeout_err,
   input  logic                  err_clear,
   output logic [pCNT_WIDTH-1:0] xfer_count
);

   localparam int unsigned TimerWidth  = timer_width(pTIMEOUT);
   localparam int unsigned TimeoutLast = (pTIMEOUT == 0) ? 0 : pTIMEOUT - 1;
   localparam bit          TimeoutEn   = (pTIMEOUT != 0);

   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutLast);
   localparam logic [TimerWidth-1:0] TimerOne  = TimerWidth'(1);
   localparam logic [pCNT_WIDTH-1:0] CntOne    = pCNT_WIDTH'(1);

   logic [1:0]            state;
   logic [TimerWidth-1:0] timer;
   logic                  ack_s;

   cdc_simple #(
      .pPIPE_DEPTH (pSYNC_DEPTH)
   ) U_ack_sync (
      .clk      (clk),
      .reset    (reset),
      .data_in  (xfer_ack),
      .data_out (ack_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         timer       <= '0;
         xfer_req    <= 1'b0;
         xfer_data   <= '0;
         timeout_err <= 1'b0;
         xfer_count  <= '0;
      end else begin
         // A timeout set below overrides this clear in the same cycle.
         if (err_clear) begin
            timeout_err <= 1'b0;
         end
         case (state)
            StIdle: begin
               if (s_valid && s_ready) begin
                  xfer_data <= s_data;
                  xfer_req  <= 1'b1;
                  timer     <= '0;
                  state     <= StReq;
               end
            end
            StReq: begin
               if (ack_s) begin
                  xfer_req   <= 1'b0;
                  xfer_count <= xfer_count + CntOne;
                  state      <= StRel;
               end else if (TimeoutEn && (timer == TimerLast)) begin
                  xfer_req    <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= StRel;
               end else if (timer != '1) begin
                  timer <= timer + TimerOne;
               end
            end
            StRel: begin
               if (!ack_s) begin
                  state <= StIdle;
               end
            end
            default: begin
               state    <= StIdle;
               xfer_req <= 1'b0;
            end
         endcase
      end
   end

   // A destination still holding ack (e.g. after a reset) blocks new words.
   assign s_ready = (state == StIdle) && !ack_s;
   assign busy    = (state != StIdle);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: scoreboarded words checked on each request,
// with a behavioural destination and directed timeout/reset/wrap cases.
module tb_cdc_handshake_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic [31:0] xfer_data;
   logic        xfer_req;
   logic        xfer_ack;
   logic        busy;
   logic        timeout_err;
   logic        err_clear = 1'b0;
   logic [3:0]  xfer_count;

   logic        resp_ack = 1'b0;
   logic        man_ack = 1'b0;
   bit          resp_en = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          hs_count = 0;
   int          exp_count = 0;
   logic [31:0] exp_q[$];

   assign xfer_ack = resp_ack | man_ack;

   always #5 clk = ~clk;

   cdc_handshake_tx #(
      .pWIDTH      (32),
      .pSYNC_DEPTH (2),
      .pTIMEOUT    (8),
      .pCNT_WIDTH  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .xfer_data   (xfer_data),
      .xfer_req    (xfer_req),
      .xfer_ack    (xfer_ack),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clear   (err_clear),
      .xfer_count  (xfer_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: each rising request must carry the oldest accepted word and
   // hold it until the request drops.
   initial begin : monitor
      logic        prev_req;
      logic [31:0] cur_word;
      prev_req = 1'b0;
      cur_word = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (xfer_req && !prev_req) begin
               hs_count++;
               if (exp_q.size() == 0) check("spurious_req", 0, 1);
               else check("xfer_data", xfer_data, exp_q.pop_front());
               cur_word = xfer_data;
            end
            if (!xfer_req && prev_req) check("data_hold", xfer_data, cur_word);
         end
         prev_req = xfer_req;
      end
   end

   // Destination: ack 2 cycles after req, release 2 cycles after req drops.
   initial begin : responder
      int n;
      forever begin
         @(negedge clk);
         if (resp_en && xfer_req && !resp_ack) begin
            repeat (2) @(negedge clk);
            resp_ack = 1'b1;
            n = 0;
            while (xfer_req && n < 100) begin
               @(negedge clk);
               n++;
            end
            if (xfer_req) check("req_release_wait", 0, 1);
            repeat (2) @(negedge clk);
            resp_ack = 1'b0;
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input bit hold);
      int n = 0;
      s_data  = d;
      s_valid = 1'b1;
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         check("accept_wait", 0, 1);
         s_valid = 1'b0;
         return;
      end
      exp_q.push_back(d);
      @(negedge clk);
      s_valid = hold;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_wait", 0, 1);
   endtask

   initial begin : main
      int n;
      int hs0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_req", xfer_req, 0);
      check("rst_data", xfer_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", timeout_err, 0);
      check("rst_count", xfer_count, 0);
      check("rst_ready", s_ready, 1);

      // Basic transfer
      resp_en = 1'b1;
      send_word(32'hA5A5_0001, 1'b0);
      wait_idle();
      exp_count = 1;
      check("basic_count", xfer_count, exp_count % 16);
      check("basic_err", timeout_err, 0);
      check("basic_ready", s_ready, 1);

      // Back-to-back with s_valid held
      hs0 = hs_count;
      for (int i = 1; i <= 4; i++) send_word(32'(i), i < 4);
      wait_idle();
      exp_count += 4;
      check("b2b_handshakes", hs_count - hs0, 4);
      check("b2b_count", xfer_count, exp_count % 16);
      check("b2b_queue_empty", exp_q.size(), 0);

      // Timeout with no ack
      resp_en = 1'b0;
      send_word(32'h0000_0077, 1'b0);
      n = 0;
      while (xfer_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("timeout_req_cycles", n, 8);
      check("timeout_err_set", timeout_err, 1);
      @(negedge clk);
      check("timeout_idle", busy, 0);
      check("timeout_count", xfer_count, exp_count % 16);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("err_cleared", timeout_err, 0);

      // err_clear coinciding with the timeout edge
      send_word(32'h0000_0088, 1'b0);
      repeat (7) @(negedge clk);
      check("err_before_timeout", timeout_err, 0);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("set_beats_clear", timeout_err, 1);
      check("req_dropped", xfer_req, 0);

      // Late ack after timeout
      man_ack = 1'b1;
      repeat (4) @(negedge clk);
      check("late_ack_ready", s_ready, 0);
      check("late_ack_busy", busy, 0);
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("late_ack_still_blocked", s_ready, 0);
      @(negedge clk);
      check("late_ack_resume", s_ready, 1);
      check("late_ack_count", xfer_count, exp_count % 16);

      // Reset mid-REQ with ack held high
      send_word(32'h0000_0055, 1'b0);
      check("req_before_reset", xfer_req, 1);
      man_ack = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_count = 0;
      check("mid_rst_req", xfer_req, 0);
      check("mid_rst_data", xfer_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_err", timeout_err, 0);
      check("mid_rst_count", xfer_count, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_ack_blocks", s_ready, 0);
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ack_still_blocked", s_ready, 0);
      @(negedge clk);
      check("rst_ack_resume", s_ready, 1);

      // Counter wrap: 17 transfers on a 4-bit counter
      resp_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         send_word(32'h0000_0100 + 32'(i), 1'b0);
         wait_idle();
      end
      exp_count += 17;
      check("wrap_count", xfer_count, exp_count % 16);
      check("wrap_queue_empty", exp_q.size(), 0);
      check("wrap_err", timeout_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side controller for a four-phase req/ack bus crossing. It accepts a pWIDTH-bit word on a valid/ready interface in the clk domain and holds it stable on xfer_data. It then sequences xfer_req against an acknowledge that returns asynchronously from the destination domain; that acknowledge is synchronized internally by one cdc_simple instance. The block sits wherever a multi-bit register or command must cross into another clock domain, paired with a destination-side receiver.

## Interface
- pWIDTH, 32: width of transferred word.
- pSYNC_DEPTH, 2: pPIPE_DEPTH passed to the ack synchronizer.
- pTIMEOUT, 1024: cycles to wait for ack high in REQ; 0 disables the timeout.
- pCNT_WIDTH, 16: width of xfer_count.

Ports:
- clk  in  1  source-domain clock.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  word offered.
- s_ready  out  1  word accepted when s_valid & s_ready.
- s_data  in  pWIDTH  word to send.
- xfer_data  out  pWIDTH  registered word; stable whenever xfer_req=1 and in REL.
- xfer_req  out  1  registered request to the destination domain.
- xfer_ack  in  1  asynchronous acknowledge from the destination.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set on timeout.
- err_clear  in  1  clears timeout_err.
- xfer_count  out  pCNT_WIDTH  completed transfers, wrapping.

## Operation
- ack_s is the data_out of cdc_simple(pPIPE_DEPTH=pSYNC_DEPTH) on xfer_ack, with the same reset.
- All FSM decisions use only ack_s, never raw xfer_ack.
- IDLE:
  - s_ready = ~ack_s.
  - On accept: latch xfer_data <= s_data, xfer_req <= 1, timer <= 0, go to REQ.
- REQ:
  - If ack_s=1: xfer_req <= 0, xfer_count++, go to REL.
  - Else if pTIMEOUT != 0 and timer == pTIMEOUT-1: xfer_req <= 0, timeout_err <= 1, go to REL.
  - Else timer++.
  - The ack test has priority over timeout in the same cycle.
- REL:
  - Wait for ack_s=0, then go to IDLE.
  - No timeout applies here.
  - xfer_data stays held.
- s_ready is 0 in REQ and REL.
- timer is wide enough for pTIMEOUT-1 and saturates; it is never compared when pTIMEOUT=0.
- timeout_err:
  - Set has priority over err_clear in the same cycle.
  - err_clear alone clears it the next cycle.
- xfer_count wraps from 2^pCNT_WIDTH-1 to 0.
- Reset values: state IDLE, xfer_req 0, xfer_data 0, timeout_err 0, xfer_count 0, timer 0, synchronizer pipe 0.
  - s_ready is 1 after reset, since ack_s=0.
  - busy is 0.
- Reset mid-transfer drops xfer_req on the next edge.
  - A destination still holding ack high blocks s_ready until ack_s falls. This is the required recovery path.

## Timing
- Accept at edge N: xfer_req=1 and xfer_data valid after edge N; s_ready=0 from the same edge.
- Synchronizer latency: an xfer_ack change is visible on ack_s after pSYNC_DEPTH+1 clk edges (3 at default).
- xfer_req falls one edge after ack_s is seen high.
- Return to IDLE is one edge after ack_s is seen low.
- Minimum round trip, with the destination responding in 0 own cycles: accept to next s_ready = 2×(pSYNC_DEPTH+1)+2 edges plus destination latency.
- The earliest IDLE re-accept is the cycle after entering IDLE (back-to-back with no bubble beyond the FSM).
- Timeout fires exactly pTIMEOUT cycles after entering REQ, counting the REQ entry cycle as timer=0.

## Structure
- Shared package holds the state encoding (IDLE=2'd0, REQ=2'd1, REL=2'd2) and the timer-width calculation ($clog2 of pTIMEOUT, minimum 1).
- One sub-module: cdc_simple, instanced as U_ack_sync.
- All other logic is a single always block plus output assigns.

## Test plan
- Basic transfer:
  - Stimulus: s_data=0xA5A5_0001 with s_valid; bench raises xfer_ack 2 cycles after seeing xfer_req and drops it 2 cycles after xfer_req falls.
  - Required: xfer_data=0xA5A5_0001 throughout; xfer_req 1 then 0; xfer_count=1; s_ready returns; timeout_err=0.
- Back-to-back:
  - Stimulus: 4 words 0x1..0x4 with s_valid held high.
  - Required: each appears on xfer_data in order, exactly one handshake each; xfer_count=4; no word is lost or duplicated.
- Timeout:
  - Stimulus: pTIMEOUT=8; ack never asserted.
  - Required: xfer_req falls after 8 REQ cycles; timeout_err=1; FSM returns to IDLE; xfer_count unchanged.
  - Then pulse err_clear: timeout_err=0. Assert err_clear on the timeout cycle: timeout_err=1.
- Late ack after timeout:
  - Stimulus: ack rises after the timeout, while in REL or IDLE.
  - Required: s_ready=0 while ack_s=1; resumes when ack drops; no count increment.
- Reset mid-REQ:
  - Stimulus: assert reset with xfer_req=1 and ack high.
  - Required: all outputs at reset values next edge; s_ready goes 1 only 3 edges after ack drops.
- Counter wrap:
  - Stimulus: pCNT_WIDTH=4 and 17 transfers.
  - Required: xfer_count=1.
